// File: rtl/lcb_packet_gate.sv
// lcb_packet_gate: collects UART bytes into fixed-length LCB packets in a two-bank
// ping-pong store and replays complete packets as stretched, gap-separated rxValid strobes.
module lcb_packet_gate #(
    parameter int DATA_W  = 8,
    parameter int PKT_LEN = 15,
    parameter int TIMEOUT = 2000,
    parameter int HOLD    = 4,
    parameter int GAP     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] uartData,
    input  logic              uartValid,
    output logic [DATA_W-1:0] rawData,
    output logic              rxValid,
    output logic              busy,
    output logic              pktOk,
    output logic              pktDrop,
    output logic [7:0]        dropCnt
);
    localparam int IDX_W  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int PH_MAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
    localparam logic [PH_W-1:0]  HOLD_END = PH_W'(HOLD - 1);
    localparam logic [PH_W-1:0]  GAP_END  = PH_W'(GAP - 1);
    localparam logic [15:0]      TMO_VAL  = 16'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_GAP} rd_state_t;

    logic [DATA_W-1:0] r_mem [2][PKT_LEN];
    logic [1:0]        r_full;

    logic              r_wr_bank;
    logic [IDX_W-1:0]  r_wr_idx;
    logic [15:0]       r_idle_cnt;
    logic              r_discard;
    logic              r_pkt_ok;
    logic              r_pkt_drop;
    logic [7:0]        r_drop_cnt;

    rd_state_t         r_state;
    logic              r_rd_bank;
    logic [IDX_W-1:0]  r_rd_idx;
    logic [PH_W-1:0]   r_ph_cnt;
    logic [DATA_W-1:0] r_raw;
    logic              r_rx_valid;
    logic              r_busy;

    logic              w_ovf;
    logic              w_take;
    logic              w_wr_last;
    logic              w_idle_run;
    logic              w_tmo;
    logic              w_tmo_drop;
    logic [1:0]        w_full_set;
    logic [1:0]        w_full_clr;

    rd_state_t         w_state_nx;
    logic [IDX_W-1:0]  w_rd_idx_nx;
    logic [PH_W-1:0]   w_ph_cnt_nx;
    logic              w_rd_free;
    logic              w_load;

    // Overflow looks at the registered full flag, so a bank freed this same cycle still counts as busy.
    assign w_ovf      = uartValid && !r_discard && (r_wr_idx == '0) && r_full[r_wr_bank];
    assign w_take     = uartValid && !r_discard && !w_ovf;
    assign w_wr_last  = w_take && (r_wr_idx == LAST_IDX);
    assign w_idle_run = (r_wr_idx != '0) || r_discard;
    assign w_tmo      = w_idle_run && !uartValid && (r_idle_cnt == TMO_VAL);
    assign w_tmo_drop = w_tmo && !r_discard;
    assign w_full_set = w_wr_last ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_full_clr = w_rd_free ? (2'b01 << r_rd_bank) : 2'b00;

    always_ff @(posedge clk) begin
        if (w_take) begin
            r_mem[r_wr_bank][r_wr_idx] <= uartData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full     <= 2'b00;
            r_wr_bank  <= 1'b0;
            r_wr_idx   <= '0;
            r_idle_cnt <= '0;
            r_discard  <= 1'b0;
            r_pkt_ok   <= 1'b0;
            r_pkt_drop <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_full     <= (r_full | w_full_set) & ~w_full_clr;
            r_pkt_ok   <= w_wr_last;
            r_pkt_drop <= w_ovf || w_tmo_drop;
            if (w_ovf || w_tmo_drop) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            if (uartValid || w_tmo) begin
                r_idle_cnt <= '0;
            end else if (w_idle_run) begin
                r_idle_cnt <= r_idle_cnt + 16'd1;
            end
            if (w_ovf) begin
                r_discard <= 1'b1;
            end else if (w_tmo && r_discard) begin
                r_discard <= 1'b0;
            end
            if (w_take) begin
                if (w_wr_last) begin
                    r_wr_idx  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_idx <= r_wr_idx + IDX_W'(1);
                end
            end else if (w_tmo_drop) begin
                r_wr_idx <= '0;
            end
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_rd_idx_nx = r_rd_idx;
        w_ph_cnt_nx = r_ph_cnt;
        w_rd_free   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_rd_idx_nx = '0;
                    w_state_nx  = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_ph_cnt_nx = '0;
                w_state_nx  = S_HOLD;
            end
            S_HOLD: begin
                if (r_ph_cnt == HOLD_END) begin
                    w_ph_cnt_nx = '0;
                    w_state_nx  = S_GAP;
                end else begin
                    w_ph_cnt_nx = r_ph_cnt + PH_W'(1);
                end
            end
            S_GAP: begin
                if (r_ph_cnt == GAP_END) begin
                    w_ph_cnt_nx = '0;
                    if (r_rd_idx == LAST_IDX) begin
                        w_rd_free  = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_rd_idx_nx = r_rd_idx + IDX_W'(1);
                        w_state_nx  = S_LOAD;
                    end
                end else begin
                    w_ph_cnt_nx = r_ph_cnt + PH_W'(1);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Strobe outputs are registered from the next state so they stay glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rd_bank  <= 1'b0;
            r_rd_idx   <= '0;
            r_ph_cnt   <= '0;
            r_raw      <= '0;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_rd_idx   <= w_rd_idx_nx;
            r_ph_cnt   <= w_ph_cnt_nx;
            r_rx_valid <= (w_state_nx == S_HOLD);
            r_busy     <= (w_state_nx != S_IDLE);
            if (w_rd_free) begin
                r_rd_bank <= ~r_rd_bank;
            end
            if (w_load) begin
                r_raw <= r_mem[r_rd_bank][r_rd_idx];
            end
        end
    end

    assign rawData = r_raw;
    assign rxValid = r_rx_valid;
    assign busy    = r_busy;
    assign pktOk   = r_pkt_ok;
    assign pktDrop = r_pkt_drop;
    assign dropCnt = r_drop_cnt;

endmodule

// File: tb/tb_lcb_packet_gate.sv
// Bench for lcb_packet_gate: directed scenarios plus random traffic, every cycle
// compared against a packet/queue-level model of the gate.
module tb_lcb_packet_gate;
    localparam int PKT  = 15;
    localparam int TMO  = 40;
    localparam int HLD  = 4;
    localparam int GP   = 16;
    localparam int PER  = 1 + HLD + GP;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] uartData;
    logic       uartValid;
    logic [7:0] rawData;
    logic       rxValid;
    logic       busy;
    logic       pktOk;
    logic       pktDrop;
    logic [7:0] dropCnt;

    lcb_packet_gate #(
        .DATA_W (8),
        .PKT_LEN(PKT),
        .TIMEOUT(TMO),
        .HOLD   (HLD),
        .GAP    (GP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .uartData (uartData),
        .uartValid(uartValid),
        .rawData  (rawData),
        .rxValid  (rxValid),
        .busy     (busy),
        .pktOk    (pktOk),
        .pktDrop  (pktDrop),
        .dropCnt  (dropCnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: bytes being gathered, stored packets (flat, 15 per packet), reader position.
    int         cyc = 0;
    bit         chk_en = 0;
    logic [7:0] m_fill[$];
    logic [7:0] m_store[$];
    bit         m_discard;
    int         m_last;
    bit         m_rd_act;
    int         m_pos;
    logic [7:0] m_raw;
    bit         m_ok, m_drop, m_rxv, m_busy;
    logic [7:0] m_cnt;
    int         last_byte_cyc;

    always @(posedge clk) begin : model
        int stored_pre;
        int widx;
        bit idle_run;
        cyc++;
        if (reset) begin
            m_fill.delete();
            m_store.delete();
            m_discard = 0;
            m_rd_act  = 0;
            m_pos     = 0;
            m_raw     = 8'h00;
            m_ok      = 0;
            m_drop    = 0;
            m_cnt     = 8'h00;
            m_rxv     = 0;
            m_busy    = 0;
            m_last    = cyc;
            chk_en    = 1;
        end else begin
            stored_pre = m_store.size() / PKT;
            widx       = m_fill.size();
            idle_run   = (widx != 0) || m_discard;
            m_ok       = 0;
            m_drop     = 0;
            if (!m_rd_act) begin
                if (stored_pre > 0) begin
                    m_rd_act = 1;
                    m_pos    = 0;
                end
            end else begin
                m_pos++;
                if (m_pos == PKT * PER) begin
                    m_rd_act = 0;
                    for (int k = 0; k < PKT; k++) void'(m_store.pop_front());
                end else if (m_pos % PER == 1) begin
                    m_raw = m_store[m_pos / PER];
                end
            end
            if (uartValid) begin
                last_byte_cyc = cyc;
                m_last = cyc;
                if (m_discard) begin
                end else if (widx == 0 && stored_pre == 2) begin
                    m_discard = 1;
                    m_drop    = 1;
                    m_cnt     = m_cnt + 8'd1;
                end else begin
                    m_fill.push_back(uartData);
                    if (m_fill.size() == PKT) begin
                        foreach (m_fill[k]) m_store.push_back(m_fill[k]);
                        m_fill.delete();
                        m_ok = 1;
                    end
                end
            end else if (idle_run && (cyc - m_last == TMO + 1)) begin
                if (widx != 0) begin
                    m_fill.delete();
                    m_drop = 1;
                    m_cnt  = m_cnt + 8'd1;
                end else begin
                    m_discard = 0;
                end
                m_last = cyc;
            end
            m_rxv  = m_rd_act && (m_pos % PER >= 1) && (m_pos % PER <= HLD);
            m_busy = m_rd_act;
        end
    end

    // Compare process plus event statistics for the directed checks.
    int         n_ok, n_drop, n_rise, ok_cyc, drop_cyc, hi_run, hi_min, hi_max;
    logic [7:0] rise_data[$];
    int         rise_cyc[$];
    logic       prev_rxv = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rawData", 32'(rawData), 32'(m_raw));
            chk("rxValid", 32'(rxValid), 32'(m_rxv));
            chk("busy",    32'(busy),    32'(m_busy));
            chk("pktOk",   32'(pktOk),   32'(m_ok));
            chk("pktDrop", 32'(pktDrop), 32'(m_drop));
            chk("dropCnt", 32'(dropCnt), 32'(m_cnt));
            if (pktOk === 1'b1) begin n_ok++; ok_cyc = cyc; end
            if (pktDrop === 1'b1) begin n_drop++; drop_cyc = cyc; end
            if (rxValid === 1'b1 && prev_rxv !== 1'b1) begin
                n_rise++;
                rise_data.push_back(rawData);
                rise_cyc.push_back(cyc);
            end
            if (rxValid === 1'b1) hi_run++;
            else if (prev_rxv === 1'b1) begin
                if (hi_run < hi_min) hi_min = hi_run;
                if (hi_run > hi_max) hi_max = hi_run;
                hi_run = 0;
            end
            prev_rxv = rxValid;
        end
    end

    task automatic clr_stats();
        n_ok = 0; n_drop = 0; n_rise = 0; ok_cyc = 0; drop_cyc = 0;
        hi_run = 0; hi_min = 9999; hi_max = 0;
        rise_data.delete();
        rise_cyc.delete();
    endtask

    task automatic send(input logic [7:0] d, input int sp);
        uartData  = d;
        uartValid = 1'b1;
        @(negedge clk);
        uartValid = 1'b0;
        repeat (sp - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input int lim);
        bit done = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (!m_rd_act && m_store.size() == 0) begin
                done = 1;
                break;
            end
        end
        chk("drain_done", 32'(done), 32'd1);
        idle(3);
    endtask

    initial begin
        int n_bad_data;
        int seen;
        bit got6;
        logic p;
        reset     = 1'b1;
        uartValid = 1'b0;
        uartData  = 8'h00;
        clr_stats();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_rawData", 32'(rawData), 32'h0);
        chk("rst_rxValid", 32'(rxValid), 32'h0);
        chk("rst_busy",    32'(busy),    32'h0);
        chk("rst_pktOk",   32'(pktOk),   32'h0);
        chk("rst_pktDrop", 32'(pktDrop), 32'h0);
        chk("rst_dropCnt", 32'(dropCnt), 32'h0);

        // One packet 0x00..0x0E, one byte every 10 clocks.
        clr_stats();
        for (int i = 0; i < PKT; i++) send(8'(i), 10);
        drain(2000);
        chk("t1_ok_cnt",   32'(n_ok),   32'd1);
        chk("t1_rise_cnt", 32'(n_rise), 32'd15);
        chk("t1_hi_min",   32'(hi_min), 32'd4);
        chk("t1_hi_max",   32'(hi_max), 32'd4);
        chk("t1_dropCnt",  32'(dropCnt), 32'd0);
        chk("t1_busy_end", 32'(busy),   32'd0);
        if (n_rise >= 2) begin
            chk("t1_latency", 32'(rise_cyc[0] - ok_cyc), 32'd2);
            chk("t1_period",  32'(rise_cyc[1] - rise_cyc[0]), 32'd21);
        end
        for (int i = 0; i < PKT && i < rise_data.size(); i++)
            chk("t1_byte", 32'(rise_data[i]), 32'(i));

        // Seven bytes then silence, followed by a good packet.
        clr_stats();
        for (int i = 0; i < 7; i++) send(8'hA0 + 8'(i), 3);
        idle(TMO + 5);
        chk("t2_drop_cnt",  32'(n_drop),  32'd1);
        chk("t2_dropCnt",   32'(dropCnt), 32'd1);
        chk("t2_no_rise",   32'(n_rise),  32'd0);
        chk("t2_drop_time", 32'(drop_cyc - last_byte_cyc), 32'(TMO + 1));
        for (int i = 0; i < PKT; i++) send(8'h20 + 8'(i), 4);
        drain(2000);
        chk("t2_rise_cnt", 32'(n_rise), 32'd15);
        if (rise_data.size() > 0) chk("t2_first_byte", 32'(rise_data[0]), 32'h20);

        // Three packets back-to-back, third must overflow.
        clr_stats();
        for (int i = 0; i < 3 * PKT; i++) send(8'h80 + 8'(i), 2);
        idle(TMO + 5);
        drain(3000);
        chk("t3_ok_cnt",   32'(n_ok),    32'd2);
        chk("t3_drop_cnt", 32'(n_drop),  32'd1);
        chk("t3_dropCnt",  32'(dropCnt), 32'd2);
        chk("t3_rise_cnt", 32'(n_rise),  32'd30);
        n_bad_data = 0;
        foreach (rise_data[k]) if (rise_data[k] >= 8'h9E && rise_data[k] <= 8'hAC) n_bad_data++;
        chk("t3_pkt3_hidden", 32'(n_bad_data), 32'd0);
        if (rise_data.size() > 15) chk("t3_pkt2_first", 32'(rise_data[15]), 32'h8F);
        for (int i = 0; i < PKT; i++) send(8'h10 + 8'(i), 2);
        drain(2000);
        chk("t3_new_ok",   32'(n_ok),   32'd3);
        chk("t3_new_rise", 32'(n_rise), 32'd45);
        if (rise_data.size() > 30) chk("t3_new_first", 32'(rise_data[30]), 32'h10);

        // Reset while the sixth replayed byte is strobing.
        for (int i = 0; i < PKT; i++) send(8'h50 + 8'(i), 1);
        seen = 0; got6 = 0; p = rxValid;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rxValid === 1'b1 && p !== 1'b1) seen++;
            p = rxValid;
            if (seen == 6) begin got6 = 1; break; end
        end
        chk("t4_reached6", 32'(got6), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t4_rxValid", 32'(rxValid), 32'd0);
        chk("t4_busy",    32'(busy),    32'd0);
        chk("t4_rawData", 32'(rawData), 32'd0);
        chk("t4_dropCnt", 32'(dropCnt), 32'd0);
        clr_stats();
        idle(400);
        chk("t4_quiet", 32'(n_rise), 32'd0);
        for (int i = 0; i < PKT; i++) send(8'h60 + 8'(i), 3);
        drain(2000);
        chk("t4_rise_cnt", 32'(n_rise), 32'd15);
        if (rise_data.size() > 0) chk("t4_first_byte", 32'(rise_data[0]), 32'h60);

        // Last byte lands exactly when the idle counter hits its limit.
        clr_stats();
        for (int i = 0; i < 13; i++) send(8'h30 + 8'(i), 3);
        send(8'h3D, TMO + 1);
        send(8'h3E, 3);
        idle(TMO + 5);
        chk("t5_ok_cnt",   32'(n_ok),   32'd1);
        chk("t5_drop_cnt", 32'(n_drop), 32'd0);
        drain(2000);
        chk("t5_rise_cnt", 32'(n_rise), 32'd15);

        // dropCnt wrap.
        clr_stats();
        for (int i = 0; i < 255; i++) begin
            send(8'(i), 1);
            idle(TMO + 3);
        end
        chk("t6_dropCnt_255", 32'(dropCnt), 32'd255);
        for (int i = 0; i < 3; i++) send(8'hC0 + 8'(i), 2);
        idle(TMO + 5);
        chk("t6_dropCnt_wrap", 32'(dropCnt), 32'd0);
        chk("t6_drop_pulses",  32'(n_drop),  32'd256);

        // Random traffic against the model.
        for (int r = 0; r < 150; r++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 6) begin
                int n;
                n = $urandom_range(1, 20);
                for (int j = 0; j < n; j++) send(8'($urandom_range(0, 255)), $urandom_range(1, 6));
            end else if (kind < 9) begin
                idle($urandom_range(0, TMO + 10));
            end else if ($urandom_range(0, 3) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end else begin
                drain(1000);
            end
        end
        idle(TMO + 5);
        drain(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcb_packet_gate.md
Name: lcb_packet_gate

Overview:
- Upstream feeder for the LCB frame assembler.
- Accepts raw bytes from the UART receiver and groups them into fixed 15-byte LCB packets. Each packet holds three groups of (1 MSB byte + 4 LSB bytes).
- Only complete packets are released downstream. Partial packets are discarded on inter-byte timeout, which keeps the assembler's byte counter aligned.
- Replays each byte as a stretched rxValid strobe with a guaranteed idle gap, so the slow multi-cycle assembler FSM never misses or double-processes a byte.

Parameters:
PKT_LEN, 15, bytes per LCB packet; byte index range 0..PKT_LEN-1.
TIMEOUT, 2000, idle clocks after a byte before a partial packet is discarded; 16-bit counter.
HOLD, 4, clocks rxValid is held high per replayed byte; must be >= 1.
GAP, 16, clocks rxValid is held low after each byte; must be >= 14 to cover the assembler's worst-case per-byte processing.

Ports:
clk  in  1  system clock; single clock domain.
reset  in  1  synchronous, active-high reset.
uartData  in  8  received byte; valid only with uartValid.
uartValid  in  1  one-clock strobe per received byte.
rawData  out  8  replayed byte to the assembler; stable for the whole HOLD+GAP window.
rxValid  out  1  byte-valid level to the assembler.
busy  out  1  high while a packet is being replayed.
pktOk  out  1  one-clock pulse when a complete packet is captured.
pktDrop  out  1  one-clock pulse when a packet is discarded (timeout or overflow).
dropCnt  out  8  wrapping count of discarded packets.

Behaviour:
- Reset (synchronous, highest priority, also when asserted mid-operation):
  - Outputs: rawData=0, rxValid=0, busy=0, pktOk=0, pktDrop=0, dropCnt=0.
  - Internal: both banks empty, wrBank=rdBank=0, wrIdx=rdIdx=0, idle counter 0, discard mode off, read FSM to IDLE.
- Storage: two banks of PKT_LEN bytes used ping-pong, each with a full flag.
- Write side:
  - On uartValid with discard mode off and bank[wrBank] not full: store the byte at [wrBank][wrIdx] and clear the idle counter.
  - If wrIdx==PKT_LEN-1: set full[wrBank], toggle wrBank, wrIdx=0, pulse pktOk the next cycle. Otherwise wrIdx+1.
- Overflow:
  - A uartValid at wrIdx==0 while full[wrBank] is set (registered value) enters discard mode, pulses pktDrop, and increments dropCnt.
  - A bank freed by the reader in the same cycle does not prevent the discard.
  - In discard mode, bytes are ignored and each one clears the idle counter.
- Timeout:
  - The idle counter runs while wrIdx!=0 or discard mode is on, and there is no uartValid.
  - When it reaches TIMEOUT with wrIdx!=0: wrIdx=0, pulse pktDrop, dropCnt+1.
  - When it reaches TIMEOUT in discard mode: discard mode is cleared with no additional count.
  - uartValid in the same cycle as the counter reaching TIMEOUT: the byte wins and the timeout does not fire.
- Read FSM:
  - IDLE: rxValid=0, busy=0. If full[rdBank]: rdIdx=0, go to LOAD.
  - LOAD (1 clk): rawData <= bank[rdBank][rdIdx], busy=1, go to HOLD.
  - HOLD (HOLD clks): rxValid=1.
  - GAP (GAP clks): rxValid=0. At the end: if rdIdx==PKT_LEN-1, clear full[rdBank], toggle rdBank, go to IDLE; else rdIdx+1 and go to LOAD.
  - A full flag set and cleared in the same cycle can only involve different banks, so no conflict exists.
- Latency:
  - The first rxValid rises 2 clocks after the pktOk pulse when the reader is idle.
  - Per-byte period is 1+HOLD+GAP = 21 clocks at defaults.
- dropCnt wraps 255 to 0.

Test Plan:
- 15 bytes 0x00..0x0E, uartValid every 10 clks -> pktOk single pulse after byte 0x0E; 15 rxValid pulses of exactly 4 clks with rawData 0x00..0x0E in order; 16-clk low gaps; busy low after the last gap; dropCnt=0.
- 7 bytes then silence -> pktDrop pulse TIMEOUT clks after the 7th byte; dropCnt=1; no rxValid. A following full 15-byte packet then replays correctly, starting at byte index 0.
- Three packets back-to-back at one byte per 2 clks (45 bytes) -> packets 1 and 2 accepted (2 pktOk pulses, 30 rxValid pulses). First byte of packet 3 triggers pktDrop, dropCnt=1, and its bytes never appear on rawData. After TIMEOUT idle, a new packet is accepted.
- Reset pulse while rxValid is high on the 6th replayed byte -> next clk rxValid=0, busy=0, rawData=0, dropCnt=0. No further strobes until a new complete packet arrives.
- 14 bytes, then the 15th byte arrives exactly TIMEOUT idle clks later -> byte accepted, pktOk pulses, no pktDrop.
- Start with dropCnt at 255 via 255 timeouts, then one more partial packet -> dropCnt=0, pktDrop pulses.
